decoder_3_8_stream: RTL and testbench
=====================================

Name: decoder_3_8_stream

Overview:
- Streaming 3-to-8 decoder; the inverse of the team's code_8_3 8-to-3 encoder.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Emits one-hot 8-bit words from a registered output stage with its own valid/ready handshake.
- Counts delivered words; used to drive one-hot select lines from encoded command streams.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of delivered-word counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  decode enable; 0 stalls the output stage.
- in_valid  input  1  din holds a code.
- in_ready  output  1  FIFO can accept; equals not-full.
- din  input  3  binary code 0..7.
- out_valid  output  1  dout holds a decoded word.
- out_ready  input  1  sink accepts dout.
- dout  output  8  one-hot decode of code; 8'h00 when out_valid=0.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- count  output  CNT_W  saturating count of output handshakes.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): FIFO empty, level=0, in_ready=1, out_valid=0, dout=8'h00, count=0.
- Mid-operation reset discards all buffered codes and the held output word.
- Push: in_valid && in_ready at a rising edge writes din at the write pointer. Pointers wrap modulo DEPTH.
- in_ready is combinational !full. No push when full, even if a pop occurs in the same cycle.
- Pop/load: at a rising edge, if en=1, FIFO non-empty, and (out_valid=0 or out_ready=1):
  - head code c is popped;
  - dout <= 8'b1 << c;
  - out_valid <= 1.
- Drain: if out_valid && out_ready and no load occurs, out_valid <= 0 and dout <= 8'h00.
- Stalled output: with out_valid=1 and out_ready=0, dout and out_valid hold unchanged regardless of en.
- en=0:
  - no load occurs;
  - FIFO still accepts pushes;
  - a word already held is still delivered when out_ready=1.
- Latency: a code pushed at edge N into an empty FIFO, with the output stage empty or draining and en=1, appears on dout with out_valid=1 after edge N+1.
- Throughput: one word per cycle with out_ready held high.
- level:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop.
- Simultaneous push and pop with the FIFO empty is not possible: a pop requires a non-empty FIFO, so the pushed code is first visible for a pop on the next edge.
- count increments on each out_valid && out_ready edge and saturates at all-ones without wrapping.
- Invariant: dout is always 8'h00 or exactly one bit set, and always 8'h00 when out_valid=0.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, dout=8'h00, level=0, count=0.
- Push codes 0..7 on consecutive cycles, out_ready=1, en=1 → dout sequence 01,02,04,08,10,20,40,80; first word valid one edge after the first push; count=8.
- out_ready=0, push 6 codes (DEPTH=4) → one word held in the output stage, level=4, in_ready=0, the 6th code is not accepted until the first edge with out_ready=1 frees an entry.
- en=0, push codes 3,5 → level=2, out_valid=0. Set en=1 → dout=8'h08, then 8'h20 on successive edges.
- Assert rst_n=0 asynchronously mid-stream with level=3 and out_valid=1 → all outputs return to reset values immediately without a clock edge.
- Force count to all-ones minus 1 (CNT_W=4 build), deliver 3 words → count=4'hF and stays there.

Source files
------------

// File: rtl/decoder_3_8_stream.sv
// Streaming 3-to-8 decoder: 3-bit codes buffered in a FIFO, emitted as one-hot words.
// Latency: code pushed at edge N into an empty FIFO is on dout after edge N+1.
// Backpressure: in_ready = FIFO not full; output word holds while out_ready=0.

module decoder_3_8_stream_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push_vld,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head_dat,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    // A full FIFO refuses pushes even when a pop frees an entry on the same edge.
    assign w_push     = i_push_vld && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_full     = (r_level == LVL_FULL);
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_head_dat = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// Top level: FIFO of codes feeding a registered one-hot output stage with a counter.
// Latency: one edge from FIFO head to dout; one word per cycle with out_ready high.
// Backpressure: output stage holds its word while out_ready=0; en=0 blocks new loads only.
module decoder_3_8_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       w_head_dat;
    logic             w_full;
    logic             w_empty;
    logic             w_load;
    logic             w_deliver;
    logic             r_out_valid;
    logic [7:0]       r_dout;
    logic [CNT_W-1:0] r_count;

    // Load when enabled, a code is waiting, and the output slot is empty or draining.
    assign w_load    = en && !w_empty && (!r_out_valid || out_ready);
    assign w_deliver = r_out_valid && out_ready;

    assign in_ready  = !w_full;
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign count     = r_count;

    decoder_3_8_stream_fifo #(
        .W     (3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (in_valid),
        .i_push_dat (din),
        .i_pop      (w_load),
        .o_head_dat (w_head_dat),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (level)
    );

    // Output register: load a fresh one-hot word, clear on drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_dout      <= 8'h00;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_dout      <= 8'h01 << w_head_dat;
        end else if (w_deliver) begin
            r_out_valid <= 1'b0;
            r_dout      <= 8'h00;
        end
    end

    // Delivered-word counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_deliver && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_decoder_3_8_stream.sv
module tb_decoder_3_8_stream;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0] din = 3'd0;
    logic in_ready, out_valid;
    logic [7:0] dout;
    logic [LW-1:0] level;
    logic [15:0] count;

    logic s_in_valid = 1'b0;
    logic [2:0] s_din = 3'd0;
    logic s_in_ready, s_out_valid;
    logic [7:0] s_dout;
    logic [LW-1:0] s_level;
    logic [3:0] s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_3_8_stream #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .level(level), .count(count)
    );

    decoder_3_8_stream #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .din(s_din), .out_valid(s_out_valid), .out_ready(1'b1), .dout(s_dout),
        .level(s_level), .count(s_count)
    );

    // Reference model: queue of pending codes, one held output word, saturating count.
    logic [2:0] m_q[$];
    bit         m_vld;
    logic [7:0] m_word;
    int         m_cnt;

    always @(posedge clk or negedge rst_n) begin
        bit ld, psh, dlv;
        if (!rst_n) begin
            m_q.delete();
            m_vld  = 0;
            m_word = 8'h00;
            m_cnt  = 0;
        end else begin
            ld  = en && (m_q.size() > 0) && (!m_vld || out_ready);
            psh = in_valid && (m_q.size() < DEPTH);
            dlv = m_vld && out_ready;
            if (dlv && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (ld) begin
                m_word = 8'(1 << m_q.pop_front());
                m_vld  = 1;
            end else if (dlv) begin
                m_vld  = 0;
                m_word = 8'h00;
            end
            if (psh) m_q.push_back(din);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = 3'd0; s_in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    endtask

    task automatic test_sequence();
        logic [7:0] got[$];
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; din = 3'(i);
            tick();
            if (i == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_latency_early got %b want 0", out_valid); end
            end
            if (i == 1) begin
                checks++; if (out_valid !== 1'b1 || dout !== 8'h01) begin errors++; $display("FAIL seq_first_word got %b/%h want 1/01", out_valid, dout); end
            end
            if (out_valid) got.push_back(dout);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) got.push_back(dout);
        end
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL seq_word_count got %0d want 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(1 << i)) begin errors++; $display("FAIL seq_word_%0d got %h want %h", i, got[i], 8'(1 << i)); end
        end
        checks++; if (count !== 16'd8) begin errors++; $display("FAIL seq_count got %0d want 8", count); end
    endtask

    task automatic test_backpressure();
        logic [2:0] c[6];
        logic [7:0] got[$];
        for (int i = 0; i < 6; i++) c[i] = 3'($urandom_range(0, 7));
        apply_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; din = c[i];
            tick();
        end
        din = c[5];
        tick(); tick();
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL bp_level_full got %0d want 4", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || dout !== 8'(1 << c[0])) begin errors++; $display("FAIL bp_held got %b/%h want 1/%h", out_valid, dout, 8'(1 << c[0])); end
        out_ready = 1'b1;
        tick();
        checks++; if (level !== LW'(3)) begin errors++; $display("FAIL bp_no_push_when_full got %0d want 3", level); end
        checks++; if (dout !== 8'(1 << c[1])) begin errors++; $display("FAIL bp_next_word got %h want %h", dout, 8'(1 << c[1])); end
        out_ready = 1'b0;
        tick();
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL bp_sixth_accepted got %0d want 4", level); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) got.push_back(dout);
        end
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL bp_drain_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(1 << c[i+2])) begin errors++; $display("FAIL bp_drain_%0d got %h want %h", i, got[i], 8'(1 << c[i+2])); end
        end
    endtask

    task automatic test_enable();
        apply_reset();
        en = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; din = 3'd3; tick();
        din = 3'd5; tick();
        in_valid = 1'b0; tick();
        checks++; if (level !== LW'(2)) begin errors++; $display("FAIL en_level got %0d want 2", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_stall got %b want 0", out_valid); end
        en = 1'b1; tick();
        checks++; if (dout !== 8'h08 || out_valid !== 1'b1) begin errors++; $display("FAIL en_word0 got %b/%h want 1/08", out_valid, dout); end
        tick();
        checks++; if (dout !== 8'h20 || out_valid !== 1'b1) begin errors++; $display("FAIL en_word1 got %b/%h want 1/20", out_valid, dout); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; din = 3'($urandom_range(0, 7)); tick();
        end
        in_valid = 1'b0;
        checks++; if (level !== LW'(3) || out_valid !== 1'b1) begin errors++; $display("FAIL ar_precond got %0d/%b want 3/1", level, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (level !== '0 || out_valid !== 1'b0 || dout !== 8'h00 || in_ready !== 1'b1 || count !== 16'd0) begin
            errors++; $display("FAIL ar_immediate got lvl=%0d vld=%b dout=%h rdy=%b cnt=%0d want 0/0/00/1/0", level, out_valid, dout, in_ready, count);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (level !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL ar_discard got %0d/%b want 0/0", level, out_valid); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) != 0);
            din       = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (dout !== m_word || out_valid !== m_vld || level !== LW'(m_q.size()) ||
                in_ready !== (m_q.size() < DEPTH) || count !== 16'(m_cnt) ||
                $countones(dout) > 1 || (!out_valid && dout !== 8'h00)) begin
                errors++;
                $display("FAIL rand_cyc%0d got dout=%h vld=%b lvl=%0d rdy=%b cnt=%0d want dout=%h vld=%b lvl=%0d cnt=%0d",
                         i, dout, out_valid, level, in_ready, count, m_word, m_vld, m_q.size(), m_cnt);
            end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            s_in_valid = 1'b1; s_din = 3'($urandom_range(0, 7)); tick();
        end
        s_in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (s_count !== 4'hE) begin errors++; $display("FAIL sat_pre got %h want e", s_count); end
        for (int i = 0; i < 3; i++) begin
            s_in_valid = 1'b1; s_din = 3'(i); tick();
        end
        s_in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (s_count !== 4'hF) begin errors++; $display("FAIL sat_max got %h want f", s_count); end
        s_in_valid = 1'b1; tick(); tick();
        s_in_valid = 1'b0; tick(); tick(); tick();
        checks++; if (s_count !== 4'hF) begin errors++; $display("FAIL sat_hold got %h want f", s_count); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_backpressure();
        test_enable();
        test_async_reset();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
